// File: rtl/inst_rom_responder.sv
// Instruction ROM responder: zero-latency fetch port plus byte-serial big-endian program loader (INST_ROM_CHECKSUM_EN adds an image checksum).
// Latency: fetch data is combinational; a loaded word is written on the edge that accepts its final byte.
// Backpressure: ld_ready_o is high only while loading; fetches return NOP (32'h0) while the loader is busy.
module inst_rom_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int CNT_W      = DEPTH_LOG2 + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [31:0]       rom_addr_i,
    output logic [31:0]       rom_data_o,
    input  logic              ld_start_i,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_byte_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    output logic              ld_busy_o,
    output logic              ld_done_o,
    output logic [CNT_W-1:0]  ld_words_o,
    output logic              ld_ovf_o,
    output logic [31:0]       ld_csum_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        mem [DEPTH];
    logic [1:0]         byte_cnt;
    logic [CNT_W-1:0]   waddr;
    logic [31:0]        asm_word;
    logic [31:0]        lane;
    logic [31:0]        wr_dat;
    logic               accept;
    logic               word_end;
    logic               full;
    logic               wr_en;
    logic               start;
    logic               in_range;
    logic [DEPTH_LOG2-1:0] fetch_idx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ld_ready_o = 1'b0;
        ld_busy_o  = 1'b0;
        ld_done_o  = 1'b0;
        case (state)
            IDLE: begin
                if (ld_start_i) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                ld_ready_o = 1'b1;
                ld_busy_o  = 1'b1;
                if (ld_valid_i && ld_last_i) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ld_done_o = 1'b1;
                ld_busy_o = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign start    = (state == IDLE) && ld_start_i;
    assign accept   = (state == LOAD) && ld_valid_i;
    assign word_end = (byte_cnt == 2'd3) || ld_last_i;
    // waddr saturates at DEPTH, so reaching it means every slot is already filled
    assign full     = (waddr == CNT_W'(DEPTH));
    assign wr_en    = rst && accept && word_end && !full;

    always_comb begin
        lane = 32'h0;
        case (byte_cnt)
            2'd0: lane = {ld_byte_i, 24'h0};
            2'd1: lane = {8'h0, ld_byte_i, 16'h0};
            2'd2: lane = {16'h0, ld_byte_i, 8'h0};
            default: lane = {24'h0, ld_byte_i};
        endcase
    end

    assign wr_dat = asm_word | lane;

    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_cnt <= 2'd0;
            waddr    <= '0;
            asm_word <= 32'h0;
            ld_ovf_o <= 1'b0;
        end else if (start) begin
            byte_cnt <= 2'd0;
            waddr    <= '0;
            asm_word <= 32'h0;
            ld_ovf_o <= 1'b0;
        end else if (accept) begin
            if (word_end) begin
                byte_cnt <= 2'd0;
                asm_word <= 32'h0;
                if (full) begin
                    ld_ovf_o <= 1'b1;
                end else begin
                    waddr <= waddr + 1'b1;
                end
            end else begin
                byte_cnt <= byte_cnt + 2'd1;
                asm_word <= wr_dat;
            end
        end
    end

    // Array contents deliberately survive reset so a program outlives a core reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr[DEPTH_LOG2-1:0]] <= wr_dat;
        end
    end

    assign ld_words_o = waddr;

`ifdef INST_ROM_CHECKSUM_EN
    logic [31:0] csum;

    always_ff @(posedge clk) begin
        if (!rst) begin
            csum <= 32'h0;
        end else if (start) begin
            csum <= 32'h0;
        end else if (wr_en) begin
            csum <= csum + wr_dat;
        end
    end

    assign ld_csum_o = csum;
`else
    assign ld_csum_o = 32'h0;
`endif

    assign in_range   = (rom_addr_i >> (DEPTH_LOG2 + 2)) == 32'h0;
    assign fetch_idx  = rom_addr_i[DEPTH_LOG2+1:2];
    assign rom_data_o = (rom_ce_i && !ld_busy_o && in_range) ? mem[fetch_idx] : 32'h0;

endmodule

// File: doc/inst_rom_responder.md
Name: inst_rom_responder

Overview:
- Responder end of the CPU instruction-fetch port. Answers the core's rom_ce/rom_addr requests with 32-bit instruction words in the same cycle.
- Contains a byte-serial program loader FSM. The loader assembles big-endian words into the instruction array and holds fetches off while loading.
- Sits beside the core top level; replaces the plain instruction ROM in simulation and FPGA builds.

Parameters:
- DEPTH_LOG2, 10, log2 of array depth in 32-bit words (default 1024 words).
- CNT_W, DEPTH_LOG2+1, width of the loaded-word counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- rom_ce_i  in  1  fetch enable from core
- rom_addr_i  in  32  fetch byte address from core
- rom_data_o  out  32  instruction word to core, combinational
- ld_start_i  in  1  pulse: begin a load at word 0
- ld_valid_i  in  1  loader byte valid
- ld_byte_i  in  8  loader byte
- ld_last_i  in  1  qualifies the final byte of the image
- ld_ready_o  out  1  loader byte accept
- ld_busy_o  out  1  load in progress (LOAD or DONE)
- ld_done_o  out  1  one-cycle pulse after the last byte is written
- ld_words_o  out  CNT_W  words written in the current or last load
- ld_ovf_o  out  1  sticky: image exceeded 2^DEPTH_LOG2 words
- ld_csum_o  out  32  image checksum (see Optional Feature)

Behaviour:
- Reset (rst=0 at edge): state=IDLE. byte_cnt=0, waddr=0, asm=0. ld_words_o=0, ld_ovf_o=0, ld_done_o=0, ld_ready_o=0, ld_busy_o=0, ld_csum_o=0. The array is not cleared; its contents are retained.
- Fetch path (combinational, zero latency):
  - Word index = rom_addr_i[DEPTH_LOG2+1:2]. rom_addr_i[1:0] is ignored.
  - rom_data_o = array[index] only when rom_ce_i=1, ld_busy_o=0, and rom_addr_i[31:DEPTH_LOG2+2]==0.
  - Otherwise rom_data_o = 32'h0 (NOP).
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - ld_ready_o=0.
  - On ld_start_i=1: go to LOAD; clear byte_cnt, waddr, ld_words_o, ld_ovf_o, ld_csum_o.
- LOAD:
  - ld_ready_o=1, ld_busy_o=1. A byte is accepted when ld_valid_i & ld_ready_o.
  - Byte k of a word (k=0..3) lands in bits [31-8k:24-8k] (big-endian).
  - On the accepted byte with byte_cnt==3, or with ld_last_i=1: write {asm lanes, current byte, zero-padded lower lanes} to array[waddr] on the same edge. Then waddr+1, ld_words_o+1, byte_cnt=0, asm=0.
  - Otherwise: byte_cnt+1 and the byte is held in asm.
  - If waddr has reached 2^DEPTH_LOG2: the write is suppressed and ld_ovf_o=1 (sticky). ld_words_o saturates at 2^DEPTH_LOG2. Bytes are still accepted until the last byte.
  - An accepted byte with ld_last_i=1 moves the FSM to DONE.
  - ld_start_i is ignored in LOAD.
- DONE: ld_done_o=1 and ld_busy_o=1 for exactly one cycle, then IDLE. ld_ready_o=0.
- ld_last_i on an empty word (byte_cnt==0) still writes one word: {byte,24'h0}.
- Reset mid-load: FSM returns to IDLE next edge. Words already written stay; the partially assembled word is lost.
- Read/write same word in one cycle: unreachable, because fetch is masked while busy.

Optional Feature:
- Macro: INST_ROM_CHECKSUM_EN.
- Defined: ld_csum_o accumulates the 32-bit wrapping sum of every word actually written (suppressed overflow writes excluded). It is cleared on ld_start_i and on reset, and holds after DONE.
- Undefined: ld_csum_o is constant 32'h0 and no adder is built.

Test Plan:
- Reset then fetch: rst=0 for 2 cycles, then rst=1 with no load. Expect all loader outputs 0. rom_ce_i=0 at any address gives rom_data_o=0.
- Full load of 8 bytes 01..08 with ld_last_i on byte 8. Expect array[0]=32'h01020304, array[1]=32'h05060708, ld_words_o=2, ld_done_o high for 1 cycle. Fetches at 0x0/0x4/0x6 then return 01020304/05060708/05060708.
- Partial word: 5 bytes AA BB CC DD EE, last on EE. Expect array[1]=32'hEE000000, ld_words_o=2. With the checksum macro defined, ld_csum_o=32'h98BBCCDD.
- Fetch masking: rom_ce_i=1 at address 0x0 during LOAD gives rom_data_o=0. An out-of-range address 0x1000 (DEPTH_LOG2=10) gives 0 when idle.
- Overflow with DEPTH_LOG2=2: load 20 bytes. Expect ld_ovf_o=1, ld_words_o=4, array[0..3] equal to the first 16 bytes, last byte still accepted, then DONE.
- Reset mid-load: assert rst=0 after 6 bytes. Expect state IDLE, ld_ready_o=0, ld_words_o=0; array[0] retains its written word.
